// File: rtl/ether_pkg.sv
// Shared definitions for the receive-side Ethernet filter: status bit
// positions, the broadcast address and the filter state encoding.
package ether_pkg;

  localparam int STATUS_CRC_ERR = 0;
  localparam int STATUS_LEN_ERR = 1;

  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WAIT,
    DECIDE,
    PASS,
    DROP,
    DONE
  } rx_state_t;

endpackage

// File: rtl/ether_da_match.sv
// Combinational accept decision: destination address against station,
// broadcast and multicast rules, gated by frame status and minimum length.
module ether_da_match
  import ether_pkg::*;
#(
  parameter bit          BROADCAST_EN = 1'b1,
  parameter bit          MULTICAST_EN = 1'b0,
  parameter bit          PROMISC      = 1'b0,
  parameter logic [15:0] MIN_LENGTH   = 16'd14
) (
  input  logic [47:0] da,
  input  logic [47:0] mac_address,
  input  logic [15:0] length,
  input  logic [1:0]  status_err,
  output logic        accept
);

  logic addr_hit;
  logic frame_ok;

  // da[40] is the group bit: bit 0 of the first byte on the wire
  always_comb begin
    addr_hit = (da == mac_address)
            || (BROADCAST_EN && (da == BCAST_ADDR))
            || (MULTICAST_EN && da[40])
            || PROMISC;
    frame_ok = !status_err[STATUS_CRC_ERR]
            && !status_err[STATUS_LEN_ERR]
            && (length >= MIN_LENGTH);
    accept   = addr_hit && frame_ok;
  end

endmodule

// File: rtl/ether_rx_filter.sv
// Receive destination-address filter: captures the first two words of each
// frame, then either drains it or replays it downstream on the same interface.
module ether_rx_filter
  import ether_pkg::*;
#(
  parameter bit          BROADCAST_EN = 1'b1,
  parameter bit          MULTICAST_EN = 1'b0,
  parameter bit          PROMISC      = 1'b0,
  parameter logic [15:0] MIN_LENGTH   = 16'd14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] mac_address,
  output logic        up_re,
  input  logic [31:0] up_data,
  input  logic        up_empty,
  input  logic        up_valid,
  input  logic [15:0] up_length,
  input  logic [15:0] up_status,
  input  logic        dn_re,
  output logic [31:0] dn_data,
  output logic        dn_empty,
  output logic        dn_valid,
  output logic [15:0] dn_length,
  output logic [15:0] dn_status,
  output logic [15:0] drop_count,
  output logic [15:0] pass_count
);

  rx_state_t   state, state_next;
  logic [14:0] nw, nw_calc, rd_cnt, hdr_words, cap_next;
  logic [1:0]  cap_cnt;
  logic [31:0] w0, w1, rep_data;
  logic [15:0] len_q, stat_q;
  logic        rep_valid, fwd_valid, dn_take, accept;

  // Word count is ceil(length/4); short frames only have nw header words
  assign nw_calc   = {1'b0, up_length[15:2]} + {14'b0, |up_length[1:0]};
  assign hdr_words = (nw >= 15'd2) ? 15'd2 : nw;
  assign cap_next  = {13'b0, cap_cnt} + {14'b0, up_valid};
  assign fwd_valid = (state == PASS) && up_valid;
  assign dn_valid  = rep_valid || fwd_valid;
  assign dn_data   = fwd_valid ? up_data : rep_data;
  assign dn_empty  = (state != PASS);

  ether_da_match #(
    .BROADCAST_EN(BROADCAST_EN),
    .MULTICAST_EN(MULTICAST_EN),
    .PROMISC     (PROMISC),
    .MIN_LENGTH  (MIN_LENGTH)
  ) u_da_match (
    .da         ({w0, w1[31:16]}),
    .mac_address(mac_address),
    .length     (len_q),
    .status_err (stat_q[1:0]),
    .accept     (accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    up_re      = 1'b0;
    dn_take    = 1'b0;
    case (state)
      IDLE:   if (!up_empty) state_next = HDR;
      HDR: begin
        up_re = (rd_cnt < hdr_words) && !up_empty;
        if ((rd_cnt + {14'b0, up_re}) >= hdr_words) state_next = WAIT;
      end
      WAIT:   if (cap_next >= hdr_words) state_next = DECIDE;
      DECIDE: state_next = accept ? PASS : DROP;
      PASS: begin
        // The first two reads are replayed; later reads pass through upstream
        if (dn_re && (rd_cnt < nw)) begin
          if (rd_cnt < 15'd2) begin
            dn_take = 1'b1;
          end else if (!up_empty) begin
            up_re   = 1'b1;
            dn_take = 1'b1;
          end
        end
        if ((rd_cnt == nw) && (dn_valid || (nw == 15'd0))) state_next = DONE;
      end
      DROP: begin
        up_re = (rd_cnt < nw) && !up_empty;
        if ((rd_cnt == nw) && (up_valid || (nw <= 15'd2))) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nw         <= '0;
      rd_cnt     <= '0;
      cap_cnt    <= '0;
      w0         <= '0;
      w1         <= '0;
      rep_data   <= '0;
      rep_valid  <= 1'b0;
      len_q      <= '0;
      stat_q     <= '0;
      dn_length  <= '0;
      dn_status  <= '0;
      drop_count <= '0;
      pass_count <= '0;
    end else begin
      rep_valid <= 1'b0;
      if (up_re || dn_take) rd_cnt <= rd_cnt + 15'd1;
      case (state)
        IDLE: if (!up_empty) begin
          len_q   <= up_length;
          stat_q  <= up_status;
          nw      <= nw_calc;
          rd_cnt  <= '0;
          cap_cnt <= '0;
          w0      <= '0;
          w1      <= '0;
        end
        HDR, WAIT: if (up_valid) begin
          if (cap_cnt == 2'd0) w0 <= up_data;
          else                 w1 <= up_data;
          cap_cnt <= cap_cnt + 2'd1;
        end
        DECIDE: begin
          if (accept) begin
            rd_cnt    <= '0;
            dn_length <= len_q;
            dn_status <= stat_q;
            if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
          end else if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
          end
        end
        PASS: if (dn_take && (rd_cnt < 15'd2)) begin
          rep_data  <= (rd_cnt == 15'd0) ? w0 : w1;
          rep_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_rx_filter.sv
// Directed bench for ether_rx_filter with a behavioural upstream frame buffer;
// a second instance with broadcast disabled shadows the first.
module tb_ether_rx_filter;

  localparam logic [47:0] MAC = 48'h0011_2233_4455;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] mac_address;
  logic        up_re, up_re_b;
  logic [31:0] up_data;
  logic        up_empty, up_valid;
  logic [15:0] up_length, up_status;
  logic        dn_re;
  logic [31:0] dn_data, dn_data_b;
  logic        dn_empty, dn_valid, dn_empty_b, dn_valid_b;
  logic [15:0] dn_length, dn_status, drop_count, pass_count;
  logic [15:0] dn_length_b, dn_status_b, drop_count_b, pass_count_b;

  logic [31:0] mem [0:1023];
  logic [15:0] fr_len [0:63];
  logic [15:0] fr_stat [0:63];
  int          fr_base [0:63];
  int          fr_nw [0:63];
  int          n_avail = 0;
  int          next_base = 0;
  int          head = 0;
  int          word_idx = 0;
  int          up_re_total = 0;
  int          re_while_empty = 0;
  logic [31:0] dn_words [0:255];
  int          dn_total = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ether_rx_filter dut (
    .clk(clk), .rst_n(rst_n), .mac_address(mac_address),
    .up_re(up_re), .up_data(up_data), .up_empty(up_empty), .up_valid(up_valid),
    .up_length(up_length), .up_status(up_status),
    .dn_re(dn_re), .dn_data(dn_data), .dn_empty(dn_empty), .dn_valid(dn_valid),
    .dn_length(dn_length), .dn_status(dn_status),
    .drop_count(drop_count), .pass_count(pass_count)
  );

  ether_rx_filter #(.BROADCAST_EN(1'b0)) dut_nobcast (
    .clk(clk), .rst_n(rst_n), .mac_address(mac_address),
    .up_re(up_re_b), .up_data(up_data), .up_empty(up_empty), .up_valid(up_valid),
    .up_length(up_length), .up_status(up_status),
    .dn_re(dn_re), .dn_data(dn_data_b), .dn_empty(dn_empty_b), .dn_valid(dn_valid_b),
    .dn_length(dn_length_b), .dn_status(dn_status_b),
    .drop_count(drop_count_b), .pass_count(pass_count_b)
  );

  always_comb begin
    up_empty  = (head >= n_avail);
    up_length = up_empty ? 16'd0 : fr_len[head[5:0]];
    up_status = up_empty ? 16'd0 : fr_stat[head[5:0]];
  end

  // Upstream buffer shares reset: a partially read head frame is discarded
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_valid <= 1'b0;
      up_data  <= 32'h0;
      if (word_idx != 0) begin
        head     <= head + 1;
        word_idx <= 0;
      end
    end else begin
      up_valid <= 1'b0;
      if (up_re) begin
        up_re_total <= up_re_total + 1;
        if (up_empty) begin
          re_while_empty <= re_while_empty + 1;
        end else begin
          up_data  <= mem[10'(fr_base[head[5:0]] + word_idx)];
          up_valid <= 1'b1;
          if (word_idx + 1 == fr_nw[head[5:0]]) begin
            head     <= head + 1;
            word_idx <= 0;
          end else begin
            word_idx <= word_idx + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dn_valid) begin
      dn_words[dn_total[7:0]] <= dn_data;
      dn_total <= dn_total + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] len, input logic [15:0] stat,
                               input logic [47:0] da, input logic [31:0] seed, output int idx);
    int nw;
    logic [31:0] w;
    nw  = (int'(len) + 3) >> 2;
    idx = n_avail;
    fr_len[idx[5:0]]  = len;
    fr_stat[idx[5:0]] = stat;
    fr_base[idx[5:0]] = next_base;
    fr_nw[idx[5:0]]   = nw;
    for (int k = 0; k < nw; k++) begin
      if (k == 0)      w = da[47:16];
      else if (k == 1) w = {da[15:0], 16'hAABB};
      else             w = seed + 32'(k);
      mem[10'(next_base + k)] = w;
    end
    next_base = next_base + nw;
    n_avail   = n_avail + 1;
  endtask

  task automatic wait_dn(input logic want, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((dn_empty !== want) && (cyc < limit));
  endtask

  task automatic read_frame(input int n, input int fr);
    int base, cyc;
    base  = dn_total;
    cyc   = 0;
    dn_re = 1'b1;
    while ((dn_total - base < n) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    dn_re = 1'b0;
    @(negedge clk);
    checkOutput("dn_word_count", 48'(dn_total - base), 48'(n));
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("dn_word%0d", k), 48'(dn_words[8'(base + k)]),
                  48'(mem[10'(fr_base[fr[5:0]] + k)]));
  endtask

  task automatic drop_frame(input logic [15:0] len, input logic [15:0] stat, input logic [47:0] da,
                            input int exp_reads, input int exp_drop);
    int base_re, idx;
    logic saw;
    base_re = up_re_total;
    saw     = 1'b0;
    applyStimulus(len, stat, da, 32'h2000_0000, idx);
    repeat (40) begin
      @(negedge clk);
      if (!dn_empty) saw = 1'b1;
    end
    checkOutput($sformatf("drop_reads_f%0d", idx), 48'(up_re_total - base_re), 48'(exp_reads));
    checkOutput($sformatf("drop_dn_empty_f%0d", idx), 48'(saw), 48'(0));
    checkOutput($sformatf("drop_count_f%0d", idx), 48'(drop_count), 48'(exp_drop));
  endtask

  initial begin
    int cyc, base, base_re, f1, f2;
    rst_n       = 1'b0;
    dn_re       = 1'b0;
    mac_address = MAC;
    repeat (3) @(negedge clk);
    checkOutput("rst_up_re", 48'(up_re), 48'(0));
    checkOutput("rst_dn_empty", 48'(dn_empty), 48'(1));
    checkOutput("rst_dn_valid", 48'(dn_valid), 48'(0));
    checkOutput("rst_dn_data", 48'(dn_data), 48'(0));
    checkOutput("rst_dn_length", 48'(dn_length), 48'(0));
    checkOutput("rst_counts", 48'({drop_count, pass_count}), 48'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Station-address match, 64 bytes
    applyStimulus(16'd64, 16'd0, MAC, 32'h1000_0000, f1);
    wait_dn(1'b0, 50, cyc);
    checkOutput("pass_latency", 48'(cyc), 48'(5));
    checkOutput("pass_dn_length", 48'(dn_length), 48'(64));
    checkOutput("pass_dn_status", 48'(dn_status), 48'(0));
    checkOutput("pass_count_1", 48'(pass_count), 48'(1));
    read_frame(16, f1);
    checkOutput("dn_empty_after_frame", 48'(dn_empty), 48'(1));

    drop_frame(16'd60, 16'd0, 48'h0011_2233_4456, 15, 1);
    drop_frame(16'd64, 16'h0001, MAC, 16, 2);
    drop_frame(16'd10, 16'd0, MAC, 3, 3);
    drop_frame(16'd60, 16'd0, 48'h0100_5E00_0001, 15, 4);
    drop_frame(16'd13, 16'd0, MAC, 4, 5);
    checkOutput("pass_count_after_drops", 48'(pass_count), 48'(1));

    // Back-to-back frames with the downstream reader stalled
    base_re = up_re_total;
    applyStimulus(16'd64, 16'd0, MAC, 32'h3000_0000, f1);
    applyStimulus(16'd14, 16'd0, MAC, 32'h4000_0000, f2);
    wait_dn(1'b0, 50, cyc);
    repeat (20) @(negedge clk);
    checkOutput("stall_up_re", 48'(up_re_total - base_re), 48'(2));
    checkOutput("stall_dn_valid", 48'(dn_valid), 48'(0));
    read_frame(16, f1);
    wait_dn(1'b0, 50, cyc);
    checkOutput("min_len_dn_length", 48'(dn_length), 48'(14));
    read_frame(4, f2);
    checkOutput("pass_count_3", 48'(pass_count), 48'(3));

    // Broadcast: the shadow instance with broadcast disabled drops it
    applyStimulus(16'd60, 16'd0, 48'hFFFF_FFFF_FFFF, 32'h5000_0000, f1);
    wait_dn(1'b0, 50, cyc);
    checkOutput("bcast_latency", 48'(cyc), 48'(5));
    checkOutput("nobcast_drop", 48'(drop_count_b), 48'(6));
    checkOutput("nobcast_pass", 48'(pass_count_b), 48'(3));
    read_frame(15, f1);
    checkOutput("bcast_pass_count", 48'(pass_count), 48'(4));

    // Reset in the middle of forwarding
    applyStimulus(16'd64, 16'd0, MAC, 32'h6000_0000, f1);
    wait_dn(1'b0, 50, cyc);
    base  = dn_total;
    cyc   = 0;
    dn_re = 1'b1;
    while ((dn_total - base < 7) && (cyc < 50)) begin
      @(negedge clk);
      cyc++;
    end
    #2 rst_n = 1'b0;
    dn_re = 1'b0;
    #1;
    checkOutput("midrst_up_re", 48'(up_re), 48'(0));
    checkOutput("midrst_dn_empty", 48'(dn_empty), 48'(1));
    checkOutput("midrst_dn_valid", 48'(dn_valid), 48'(0));
    checkOutput("midrst_dn_data", 48'(dn_data), 48'(0));
    checkOutput("midrst_dn_len_stat", 48'({dn_length, dn_status}), 48'(0));
    checkOutput("midrst_counts", 48'({drop_count, pass_count}), 48'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'd20, 16'd0, MAC, 32'h7000_0000, f1);
    wait_dn(1'b0, 50, cyc);
    checkOutput("post_rst_latency", 48'(cyc), 48'(5));
    read_frame(5, f1);
    checkOutput("post_rst_counts", 48'({drop_count, pass_count}), 48'({16'd0, 16'd1}));
    checkOutput("up_re_while_empty", 48'(re_while_empty), 48'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
